// File: rtl/logic_gate_bank_pipe.sv
// rtl/logic_gate_bank_pipe.sv - WIDTH-channel selectable 2-input gate bank with PIPE-stage output
// pipeline, valid/ready handshake and a built-in self-test sequencer.
module logic_gate_bank_pipe #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y,
  input  logic             fault_inj,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass
);

  // Bit n of the golden table is the gate output for mode=n[4:2], a=n[1], b=n[0].
  localparam logic [31:0] GOLDEN = 32'hC39617E8;

  typedef enum logic [2:0] {IDLE, DRAIN, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic             fail;
  logic [WIDTH-1:0] sd  [PIPE];
  logic [WIDTH-1:0] din [PIPE];
  logic [PIPE-1:0]  sv;
  logic [PIPE-1:0]  st;
  logic [PIPE-1:0]  se;
  logic             stall, run, adv, mis;
  logic [2:0]       g_mode;
  logic [WIDTH-1:0] g_a, g_b, gate_y;

  assign y_valid  = sv[PIPE-1];
  assign y        = sd[PIPE-1];
  assign stall    = y_valid & ~y_ready;
  assign in_ready = ~stall & ~bist_busy;
  assign run      = (state == RUN);
  assign adv      = ~stall | run;

  assign g_mode = run ? cnt[4:2] : mode;
  assign g_a    = run ? {WIDTH{cnt[1]}} : a;
  assign g_b    = run ? {WIDTH{cnt[0]}} : b;

  always_comb begin
    gate_y = '0;
    case (g_mode)
      3'd0: gate_y = g_a & g_b;
      3'd1: gate_y = g_a | g_b;
      3'd2: gate_y = ~(g_a & g_b);
      3'd3: gate_y = ~(g_a | g_b);
      3'd4: gate_y = g_a ^ g_b;
      3'd5: gate_y = ~(g_a ^ g_b);
      3'd6: gate_y = ~g_a;
      3'd7: gate_y = g_a;
    endcase
  end

  // Fault injection lands only on the load of the last stage.
  always_comb begin
    din[0] = gate_y;
    for (int i = 1; i < PIPE; i++) din[i] = sd[i-1];
    din[PIPE-1][0] = din[PIPE-1][0] ^ fault_inj;
  end

  // st marks self-test vectors, se carries their expected bit alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) sd[i] <= '0;
      sv <= '0;
      st <= '0;
      se <= '0;
    end else if (adv) begin
      for (int i = 0; i < PIPE; i++) sd[i] <= din[i];
      sv[0] <= in_valid & in_ready;
      st[0] <= run;
      se[0] <= GOLDEN[cnt];
      for (int i = 1; i < PIPE; i++) begin
        sv[i] <= sv[i-1];
        st[i] <= st[i-1];
        se[i] <= se[i-1];
      end
    end
  end

  assign mis = st[PIPE-1] & (sd[PIPE-1] != {WIDTH{se[PIPE-1]}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fail      <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      bist_done <= 1'b0;
      if (mis) fail <= 1'b1;
      case (state)
        IDLE: if (bist_start) begin
          state     <= DRAIN;
          bist_busy <= 1'b1;
          bist_pass <= 1'b0;
          fail      <= 1'b0;
        end
        DRAIN: if (sv == '0) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          if (cnt == 5'd31) begin
            state <= FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FLUSH: begin
          if (cnt == 5'(PIPE - 1)) state <= DONE;
          else cnt <= cnt + 5'd1;
        end
        DONE: begin
          bist_done <= 1'b1;
          bist_pass <= ~fail;
          bist_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
